// File: rtl/wave_channel_param.sv
// Parametrised wave channel: period timer, linear and length counters, and a step
// sequencer that produces triangle, sawtooth or square samples arithmetically.
module wave_channel_param #(
    parameter int TIMER_W  = 11,
    parameter int SEQ_LOG2 = 5,
    parameter int OUT_W    = 4,
    parameter int LIN_W    = 7,
    parameter int MIN_PER  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_clk_en,
    input  logic                quarter_clk_en,
    input  logic                half_clk_en,
    input  logic                enable,
    input  logic                length_halt,
    input  logic                linear_load,
    input  logic [LIN_W-1:0]    linear_load_data,
    input  logic                period_load,
    input  logic [TIMER_W-1:0]  period_load_data,
    input  logic                length_load,
    input  logic [4:0]          length_load_data,
    input  logic [1:0]          mode,
    output logic                length_non_zero,
    output logic                linear_non_zero,
    output logic [SEQ_LOG2-1:0] seq_step,
    output logic [OUT_W-1:0]    wave
);

    localparam int TRI_W = SEQ_LOG2 - 1;
    localparam logic [TIMER_W-1:0] MIN_PER_V = TIMER_W'(MIN_PER);

    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [TIMER_W-1:0]  period_q, period_d;
    logic [LIN_W-1:0]    lin_q, lin_d;
    logic [LIN_W-1:0]    reload_val_q, reload_val_d;
    logic                lin_reload_q, lin_reload_d;
    logic [7:0]          len_q, len_d;
    logic [SEQ_LOG2-1:0] seq_q, seq_d;
    logic [OUT_W-1:0]    wave_q, wave_d;

    logic                tick;
    logic                reload_eff;
    logic                period_ok;
    logic [TRI_W-1:0]    tri_lvl;
    logic [OUT_W-1:0]    tri_out;
    logic [OUT_W-1:0]    saw_out;
    logic [OUT_W-1:0]    sqr_out;

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
            5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
            5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
            5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
            5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
            5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
        endcase
        return v;
    endfunction

    // Lower half counts down from H-1, upper half counts up: H-1-s is the complement of the low bits.
    assign tri_lvl = seq_q[SEQ_LOG2-1] ? seq_q[TRI_W-1:0] : ~seq_q[TRI_W-1:0];

    generate
        if (TRI_W >= OUT_W) begin : g_tri_top
            assign tri_out = tri_lvl[TRI_W-1 -: OUT_W];
        end else begin : g_tri_shl
            assign tri_out = {tri_lvl, {(OUT_W-TRI_W){1'b0}}};
        end
        if (SEQ_LOG2 >= OUT_W) begin : g_saw_top
            assign saw_out = seq_q[SEQ_LOG2-1 -: OUT_W];
        end else begin : g_saw_shl
            assign saw_out = {seq_q, {(OUT_W-SEQ_LOG2){1'b0}}};
        end
    endgenerate

    assign sqr_out   = {OUT_W{seq_q[SEQ_LOG2-1]}};
    assign period_ok = (MIN_PER == 0) || (period_q >= MIN_PER_V);

    always_comb begin
        timer_d      = timer_q;
        tick         = 1'b0;
        period_d     = period_q;
        reload_val_d = reload_val_q;
        reload_eff   = lin_reload_q | linear_load;
        lin_d        = lin_q;
        lin_reload_d = reload_eff;
        len_d        = len_q;
        seq_d        = seq_q;
        wave_d       = wave_q;

        if (cpu_clk_en) begin
            if (timer_q == '0) begin
                timer_d = period_q;
                tick    = 1'b1;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        if (period_load) begin
            period_d = period_load_data;
        end

        // A load coinciding with the quarter tick is already visible to that tick.
        if (linear_load) begin
            reload_val_d = linear_load_data;
        end
        if (quarter_clk_en) begin
            if (reload_eff) begin
                lin_d = reload_val_d;
            end else if (lin_q != '0) begin
                lin_d = lin_q - 1'b1;
            end
            if (!length_halt) begin
                lin_reload_d = 1'b0;
            end
        end

        if (!enable) begin
            len_d = 8'd0;
        end else if (length_load) begin
            len_d = len_lookup(length_load_data);
        end else if (half_clk_en && !length_halt && len_q != 8'd0) begin
            len_d = len_q - 8'd1;
        end

        if (tick && lin_q != '0 && len_q != 8'd0 && period_ok) begin
            seq_d = seq_q + 1'b1;
        end

        case (mode)
            2'b01:   wave_d = saw_out;
            2'b10:   wave_d = sqr_out;
            default: wave_d = tri_out;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q      <= '0;
            period_q     <= '0;
            lin_q        <= '0;
            reload_val_q <= '0;
            lin_reload_q <= 1'b0;
            len_q        <= 8'd0;
            seq_q        <= '0;
            wave_q       <= '0;
        end else begin
            timer_q      <= timer_d;
            period_q     <= period_d;
            lin_q        <= lin_d;
            reload_val_q <= reload_val_d;
            lin_reload_q <= lin_reload_d;
            len_q        <= len_d;
            seq_q        <= seq_d;
            wave_q       <= wave_d;
        end
    end

    assign length_non_zero = (len_q != 8'd0);
    assign linear_non_zero = (lin_q != '0);
    assign seq_step        = seq_q;
    assign wave            = wave_q;

endmodule

// File: tb/tb_wave_channel_param.sv
// Self-checking bench for wave_channel_param at default parameters.
module tb_wave_channel_param;

    logic       clk;
    logic       rst;
    logic       cpu_clk_en, quarter_clk_en, half_clk_en;
    logic       enable, length_halt;
    logic       linear_load;
    logic [6:0] linear_load_data;
    logic       period_load;
    logic [10:0] period_load_data;
    logic       length_load;
    logic [4:0] length_load_data;
    logic [1:0] mode;
    logic       length_non_zero, linear_non_zero;
    logic [4:0] seq_step;
    logic [3:0] wave;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [3:0] wave; logic [4:0] step; } sb_t;
    typedef struct { logic [1:0] mode; int step; logic [3:0] wave; } wv_t;
    typedef struct { logic [4:0] idx; int len; } lv_t;

    sb_t sbq[$];
    wv_t wtab[12];
    lv_t ltab[7];

    wave_channel_param dut (
        .clk(clk), .rst(rst),
        .cpu_clk_en(cpu_clk_en), .quarter_clk_en(quarter_clk_en), .half_clk_en(half_clk_en),
        .enable(enable), .length_halt(length_halt),
        .linear_load(linear_load), .linear_load_data(linear_load_data),
        .period_load(period_load), .period_load_data(period_load_data),
        .length_load(length_load), .length_load_data(length_load_data),
        .mode(mode),
        .length_non_zero(length_non_zero), .linear_non_zero(linear_non_zero),
        .seq_step(seq_step), .wave(wave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_wave(input logic [1:0] m, input int s);
        case (m)
            2'b01:   return 4'(s / 2);
            2'b10:   return (s >= 16) ? 4'd15 : 4'd0;
            default: return (s < 16) ? 4'(15 - s) : 4'(s - 16);
        endcase
    endfunction

    task automatic advance_to(input int target);
        int n;
        n = 0;
        cpu_clk_en = 1'b1;
        while (int'(seq_step) != target && n < 200) begin
            cyc();
            n++;
        end
        cpu_clk_en = 1'b0;
        if (n >= 200) check("advance_timeout", int'(seq_step), target);
    endtask

    initial begin
        int tcnt, mstep, n;
        bit tick;
        sb_t e, got;
        int ph_mode[4] = '{0, 1, 2, 0};
        int ph_len[4]  = '{136, 136, 136, 8};

        wtab[0]  = '{2'd0, 5, 4'd10};  wtab[1]  = '{2'd0, 15, 4'd0};
        wtab[2]  = '{2'd0, 16, 4'd0};  wtab[3]  = '{2'd0, 31, 4'd15};
        wtab[4]  = '{2'd1, 2, 4'd1};   wtab[5]  = '{2'd1, 17, 4'd8};
        wtab[6]  = '{2'd1, 31, 4'd15}; wtab[7]  = '{2'd2, 15, 4'd0};
        wtab[8]  = '{2'd2, 16, 4'd15}; wtab[9]  = '{2'd3, 20, 4'd4};
        wtab[10] = '{2'd0, 0, 4'd15};  wtab[11] = '{2'd0, 7, 4'd8};
        ltab[0] = '{5'd3, 2};   ltab[1] = '{5'd0, 10};  ltab[2] = '{5'd12, 14};
        ltab[3] = '{5'd16, 12}; ltab[4] = '{5'd30, 32}; ltab[5] = '{5'd26, 72};
        ltab[6] = '{5'd9, 8};

        rst = 1'b1;
        cpu_clk_en = 0; quarter_clk_en = 0; half_clk_en = 0;
        enable = 0; length_halt = 0; linear_load = 0; linear_load_data = '0;
        period_load = 0; period_load_data = '0; length_load = 0; length_load_data = '0;
        mode = 2'b00;
        cyc(); cyc();
        check("rst_wave", int'(wave), 0);
        check("rst_step", int'(seq_step), 0);
        check("rst_len_nz", int'(length_non_zero), 0);
        check("rst_lin_nz", int'(linear_non_zero), 0);
        rst = 1'b0;
        cyc();

        // Channel setup: period 3, length 254, linear 127 loaded on a quarter tick.
        enable = 1; period_load = 1; period_load_data = 11'd3;
        length_load = 1; length_load_data = 5'd1;
        linear_load = 1; linear_load_data = 7'd127; quarter_clk_en = 1;
        cyc();
        period_load = 0; length_load = 0; linear_load = 0; quarter_clk_en = 0;
        check("setup_len_nz", int'(length_non_zero), 1);
        check("setup_lin_nz", int'(linear_non_zero), 1);

        // Scoreboarded free run across modes; timer model starts at count 0.
        tcnt = 0; mstep = 0;
        cpu_clk_en = 1;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                mode = 2'(ph_mode[p]);
                tick = (tcnt == 0);
                tcnt = tick ? 3 : tcnt - 1;
                e.wave = exp_wave(mode, mstep);
                if (tick) mstep = (mstep + 1) % 32;
                e.step = 5'(mstep);
                sbq.push_back(e);
                cyc();
                got = sbq.pop_front();
                check("run_wave", int'(wave), int'(got.wave));
                check("run_step", int'(seq_step), int'(got.step));
            end
        end
        cpu_clk_en = 0;

        for (int i = 0; i < 12; i++) begin
            advance_to(wtab[i].step);
            mode = wtab[i].mode;
            cyc();
            check($sformatf("wtab%0d_wave", i), int'(wave), int'(wtab[i].wave));
        end

        for (int i = 0; i < 7; i++) begin
            length_load = 1; length_load_data = ltab[i].idx;
            cyc();
            length_load = 0; half_clk_en = 1;
            n = 0;
            while (length_non_zero && n < 300) begin
                cyc();
                n++;
            end
            half_clk_en = 0;
            check($sformatf("ltab%0d_len", i), n, ltab[i].len);
        end

        // Linear counter runs out and freezes the sequencer at step 7.
        length_load = 1; length_load_data = 5'd1;
        linear_load = 1; linear_load_data = 7'd2;
        cyc();
        length_load = 0; linear_load = 0; quarter_clk_en = 1;
        cyc(); check("lin_2", int'(linear_non_zero), 1);
        cyc(); check("lin_1", int'(linear_non_zero), 1);
        cyc(); check("lin_0", int'(linear_non_zero), 0);
        quarter_clk_en = 0; cpu_clk_en = 1;
        for (int i = 0; i < 40; i++) cyc();
        cpu_clk_en = 0;
        check("freeze_step", int'(seq_step), 7);
        check("freeze_wave", int'(wave), int'(exp_wave(2'd0, 7)));

        // Halt keeps the reload flag set across quarter ticks.
        length_halt = 1; linear_load = 1; linear_load_data = 7'd1; quarter_clk_en = 1;
        cyc(); check("halt_load", int'(linear_non_zero), 1);
        linear_load = 0;
        cyc(); check("halt_reload", int'(linear_non_zero), 1);
        length_halt = 0;
        cyc(); check("unhalt_reload", int'(linear_non_zero), 1);
        cyc(); check("unhalt_dec", int'(linear_non_zero), 0);
        quarter_clk_en = 0;

        length_load = 1; length_load_data = 5'd0;
        cyc(); check("en_len10", int'(length_non_zero), 1);
        length_load = 0; enable = 0;
        cyc(); check("dis_clear", int'(length_non_zero), 0);
        length_load = 1; length_load_data = 5'd1;
        cyc(); check("dis_load_ignored", int'(length_non_zero), 0);
        length_load = 0; enable = 1;

        // Load beats a same-cycle half tick: count is 2 afterwards.
        length_load = 1; length_load_data = 5'd3; half_clk_en = 1;
        cyc(); check("load_vs_half", int'(length_non_zero), 1);
        length_load = 0; length_halt = 1;
        cyc(); cyc(); check("len_halted", int'(length_non_zero), 1);
        length_halt = 0;
        cyc(); check("len_dec_1", int'(length_non_zero), 1);
        cyc(); check("len_dec_0", int'(length_non_zero), 0);
        half_clk_en = 0;

        // Ultrasonic guard: period 1 ticks but never steps; period 2 steps again.
        length_load = 1; length_load_data = 5'd1;
        linear_load = 1; linear_load_data = 7'd127; quarter_clk_en = 1;
        period_load = 1; period_load_data = 11'd1;
        cyc();
        length_load = 0; linear_load = 0; quarter_clk_en = 0; period_load = 0;
        cpu_clk_en = 1;
        for (int i = 0; i < 30; i++) cyc();
        check("guard_step", int'(seq_step), 7);
        period_load = 1; period_load_data = 11'd2;
        cyc();
        period_load = 0;
        for (int i = 0; i < 12; i++) cyc();
        check("guard_release", int'(seq_step != 5'd7), 1);
        check("pre_rst_len_nz", int'(length_non_zero), 1);

        // Asynchronous reset between clock edges.
        rst = 1'b1;
        #2;
        check("mid_rst_step", int'(seq_step), 0);
        check("mid_rst_wave", int'(wave), 0);
        check("mid_rst_len_nz", int'(length_non_zero), 0);
        check("mid_rst_lin_nz", int'(linear_non_zero), 0);
        cyc();
        check("held_rst_step", int'(seq_step), 0);
        rst = 1'b0;
        cpu_clk_en = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
